decode_issue: RTL and testbench
===============================

DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: inst_valid in 1 / inst_ready out 1 / inst in 32 / pc in 32  instruction input handshake.
REQ-004 SHALL: iss_valid out 1 / iss_ready in 1  issue handshake toward the ALU stage.
REQ-005 SHALL: opcode out 5 (inst[6:2]), func3 out 3 (inst[14:12]), func7 out 1  ALU control.
REQ-006 SHALL: alu_src1 out 32, alu_src2 out 32  ALU operands.
REQ-007 SHALL: iss_rs2_data out 32 (store data), iss_imm out 32 (branch/jump offset), iss_rd out 5, iss_wen out 1, iss_illegal out 1.
REQ-008 SHALL: wb_valid in 1, wb_rd in 5, wb_data in 32  register writeback port.

Function
REQ-009 SHALL: hold one output pipeline register; transfer on inst_valid && inst_ready; issue completes on iss_valid && iss_ready.
REQ-010 SHALL: inst_ready = (!iss_valid || iss_ready) && !hazard.
REQ-011 SHALL: iss_valid and all iss_* outputs stay stable while iss_valid && !iss_ready.
REQ-012 SHALL: iss_valid deassert after a completed issue when no new instruction is accepted in the same cycle.
REQ-013 SHALL: contain a 31x32 register file; x0 reads 0; writes to x0 are ignored.
REQ-014 SHALL: on wb_valid, write wb_data to wb_rd at the clock edge and clear pending[wb_rd].
REQ-015 SHALL: keep a 32-bit pending scoreboard; set pending[rd] on acceptance when wen && rd!=0.
REQ-016 SHALL: hazard = a used rs1/rs2 (nonzero) has pending set and is not matched by a same-cycle wb_rd with wb_valid.
REQ-017 SHALL: bypass wb_data into the operand when wb_valid && wb_rd==rs && rs!=0.
REQ-018 SHALL: when a writeback clears and an acceptance sets the same rd in one cycle, the set wins.
REQ-019 SHALL: R_R(01100): src1=rs1, src2=rs2, wen=1; func7=inst[30].
REQ-020 SHALL: R_I(00100): src1=rs1, src2=sext I-imm (shamt inst[24:20] zero-extended for func3 001/101); wen=1; func7=inst[30] only when func3=101, else 0.
REQ-021 SHALL: LUI(01101): src1=0, src2={inst[31:12],12'b0}; AUIPC(00101): src1=pc, src2=U-imm; wen=1.
REQ-022 SHALL: LOAD(00000): src1=rs1, src2=I-imm, wen=1; STORE(01000): src1=rs1, src2=S-imm, iss_rs2_data=rs2, wen=0.
REQ-023 SHALL: JAL(11011): src1=pc, src2=0, iss_imm=J-imm, wen=1; JALR(11001): src1=pc, src2=0, iss_imm=I-imm, uses rs1 via iss_rs2_data=rs1, wen=1.
REQ-024 SHALL: BRANCH(11000): src1=rs1, src2=rs2, iss_imm=B-imm, wen=0.
REQ-025 SHALL: any other opcode, or inst[1:0]!=11: issue with iss_illegal=1, wen=0, operands 0; scoreboard unchanged.
REQ-026 SHALL: func7 output 0 for all non-R_R/R_I opcodes; all immediates sign-extended to 32 bits.

Reset
REQ-027 SHALL: while rst_n=0, iss_valid=0 and every iss_*/opcode/func/alu_src output = 0.
REQ-028 SHALL: reset clear the pending scoreboard and all register-file entries to 0.
REQ-029 SHALL: reset mid-stall drop the held instruction; inst_ready=1 in the first cycle after release.

Structure
REQ-030 SHALL: put opcode constants (R_R, R_I, LUI, AUIPC, LOAD, STORE, JAL, JALR, BRANCH) in shared package riscv_pkg, also used by the ALU.
REQ-031 SHALL: implement immediate generation as combinational sub-module imm_gen; the register file stays inline.

Verification
REQ-032 SHALL: cover: after wb x1=5, x2=7, inject ADD x3,x1,x2 -> opcode=01100, func3=000, func7=0, src1=5, src2=7, wen=1, rd=3.
REQ-033 SHALL: cover: ADDI x4,x3,-1 issued while x3 pending, no wb -> inst_ready=0 and no issue until wb x3=12; in the wb cycle the instruction is accepted with bypass, src1=12, src2=0xFFFFFFFF.
REQ-034 SHALL: cover: SRAI x5,x1,3 (inst[30]=1) -> func3=101, func7=1, src2=3.
REQ-035 SHALL: cover: iss_ready=0 for 4 cycles holding LUI x6,0x12345 -> src2=0x12345000 stable, inst_ready=0, then single issue.
REQ-036 SHALL: cover: inst=0xFFFFFFFF -> iss_illegal=1, wen=0; then rst_n pulse mid-stall -> all outputs 0, pending cleared.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode constants (inst[6:2]) and payload types.
package riscv_pkg;

  localparam logic [4:0] OP_R_R    = 5'b01100;
  localparam logic [4:0] OP_R_I    = 5'b00100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;

  // All immediate formats, sign-extended to 32 bits.
  typedef struct packed {
    logic [31:0] i;
    logic [31:0] s;
    logic [31:0] b;
    logic [31:0] u;
    logic [31:0] j;
  } imm_t;

  // Contents of the issue pipeline register.
  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic        func7;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } iss_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: every RV32 immediate format from one instruction word.
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] inst_i,
  output imm_t        imm_o
);

  // Pure bit-slicing; the consumer picks the format it needs.
  always_comb begin
    imm_o.i = {{20{inst_i[31]}}, inst_i[31:20]};
    imm_o.s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    imm_o.b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    imm_o.u = {inst_i[31:12], 12'b0};
    imm_o.j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  end

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: register file, pending scoreboard, operand bypass and one issue register.
module decode_issue
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [4:0]  opcode,
  output logic [2:0]  func3,
  output logic        func7,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [31:0] iss_rs2_data,
  output logic [31:0] iss_imm,
  output logic [4:0]  iss_rd,
  output logic        iss_wen,
  output logic        iss_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data
);

  logic [31:0] rf_q [1:31];
  logic [31:0] pend_q, pend_d;
  iss_t        iss_q, dec;
  logic        iss_valid_q;
  imm_t        imm;
  logic [4:0]  rs1, rs2, inst_rd;
  logic [31:0] r1v, r2v;
  logic        use1, use2, hazard, accept;

  assign rs1     = inst[19:15];
  assign rs2     = inst[24:20];
  assign inst_rd = inst[11:7];

  imm_gen u_imm (.inst_i(inst), .imm_o(imm));

  // Register-file reads; a same-cycle writeback is forwarded so it can resolve a hazard.
  always_comb begin
    r1v = '0;
    r2v = '0;
    if (rs1 != 5'd0) r1v = (wb_valid && wb_rd == rs1) ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0) r2v = (wb_valid && wb_rd == rs2) ? wb_data : rf_q[rs2];
  end

  // Decode into the issue payload; unused fields stay zero so illegal ops issue as all-zero.
  always_comb begin
    dec        = '0;
    use1       = 1'b0;
    use2       = 1'b0;
    dec.opcode = inst[6:2];
    dec.func3  = inst[14:12];
    if (inst[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (inst[6:2])
        OP_R_R: begin
          dec.src1 = r1v; dec.src2 = r2v; dec.wen = 1'b1; dec.func7 = inst[30];
          use1 = 1'b1; use2 = 1'b1;
        end
        OP_R_I: begin
          // func3 001/101 are shifts: shamt only, upper bits select SRL vs SRA
          dec.src1  = r1v;
          dec.src2  = (inst[13:12] == 2'b01) ? {27'd0, inst[24:20]} : imm.i;
          dec.func7 = (inst[14:12] == 3'b101) && inst[30];
          dec.wen   = 1'b1; use1 = 1'b1;
        end
        OP_LUI:   begin dec.src2 = imm.u; dec.wen = 1'b1; end
        OP_AUIPC: begin dec.src1 = pc; dec.src2 = imm.u; dec.wen = 1'b1; end
        OP_LOAD:  begin dec.src1 = r1v; dec.src2 = imm.i; dec.wen = 1'b1; use1 = 1'b1; end
        OP_STORE: begin
          dec.src1 = r1v; dec.src2 = imm.s; dec.rs2_data = r2v;
          use1 = 1'b1; use2 = 1'b1;
        end
        OP_JAL:   begin dec.src1 = pc; dec.imm = imm.j; dec.wen = 1'b1; end
        // JALR target base travels on the store-data lane
        OP_JALR:  begin
          dec.src1 = pc; dec.imm = imm.i; dec.rs2_data = r1v; dec.wen = 1'b1; use1 = 1'b1;
        end
        OP_BRANCH: begin
          dec.src1 = r1v; dec.src2 = r2v; dec.imm = imm.b; use1 = 1'b1; use2 = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    if (dec.wen) dec.rd = inst_rd;
  end

  assign hazard = (use1 && rs1 != 5'd0 && pend_q[rs1] && !(wb_valid && wb_rd == rs1)) ||
                  (use2 && rs2 != 5'd0 && pend_q[rs2] && !(wb_valid && wb_rd == rs2));
  assign inst_ready = (!iss_valid_q || iss_ready) && !hazard;
  assign accept     = inst_valid && inst_ready;

  // Scoreboard next state: writeback clears first so a same-cycle acceptance wins.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid) pend_d[wb_rd] = 1'b0;
    if (accept && dec.wen && inst_rd != 5'd0) pend_d[inst_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Register file writes; x0 has no storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < 32; k++) rf_q[k] <= '0;
    end else if (wb_valid && wb_rd != 5'd0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  // Issue register: load on accept, drop valid after a completed issue, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q <= 1'b0;
      iss_q       <= '0;
    end else if (accept) begin
      iss_valid_q <= 1'b1;
      iss_q       <= dec;
    end else if (iss_ready) begin
      iss_valid_q <= 1'b0;
    end
  end

  assign iss_valid    = iss_valid_q;
  assign opcode       = iss_q.opcode;
  assign func3        = iss_q.func3;
  assign func7        = iss_q.func7;
  assign alu_src1     = iss_q.src1;
  assign alu_src2     = iss_q.src2;
  assign iss_rs2_data = iss_q.rs2_data;
  assign iss_imm      = iss_q.imm;
  assign iss_rd       = iss_q.rd;
  assign iss_wen      = iss_q.wen;
  assign iss_illegal  = iss_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios then random traffic against a behavioural model.
module tb_decode_issue;

  logic        clk = 1'b0, rst_n;
  logic        inst_valid, inst_ready, iss_valid, iss_ready;
  logic [31:0] inst, pc, alu_src1, alu_src2, iss_rs2_data, iss_imm, wb_data;
  logic [4:0]  opcode, iss_rd, wb_rd;
  logic [2:0]  func3;
  logic        func7, iss_wen, iss_illegal, wb_valid;

  always #5 clk = ~clk;

  decode_issue dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .pc(pc),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .opcode(opcode), .func3(func3), .func7(func7),
    .alu_src1(alu_src1), .alu_src2(alu_src2),
    .iss_rs2_data(iss_rs2_data), .iss_imm(iss_imm), .iss_rd(iss_rd),
    .iss_wen(iss_wen), .iss_illegal(iss_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  typedef struct packed {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] s1, s2, sd, imm;
    logic [4:0]  rd;
    logic        wen, ill;
  } exp_t;

  int checks = 0, errors = 0;

  // Architectural model state
  logic [31:0] m_rf [32];
  bit   [31:0] m_pend;
  bit          m_vld;
  exp_t        m_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (wb_valid && wb_rd == r) return wb_data;
    return m_rf[r];
  endfunction

  // Which source registers an instruction reads: bit0 = rs1, bit1 = rs2.
  function automatic logic [1:0] uses(input logic [31:0] i);
    if (i[1:0] != 2'b11) return 2'b00;
    case (i[6:2])
      5'b01100, 5'b01000, 5'b11000: return 2'b11;
      5'b00100, 5'b00000, 5'b11001: return 2'b01;
      default:                      return 2'b00;
    endcase
  endfunction

  function automatic bit blocked(input logic [4:0] r);
    return r != 5'd0 && m_pend[r] && !(wb_valid && wb_rd == r);
  endfunction

  function automatic bit m_hazard(input logic [31:0] i);
    logic [1:0] u = uses(i);
    return (u[0] && blocked(i[19:15])) || (u[1] && blocked(i[24:20]));
  endfunction

  function automatic exp_t model_dec(input logic [31:0] i, input logic [31:0] p);
    exp_t e;
    logic [31:0] ii, si, bi, ui, ji;
    ii = 32'($signed(i[31:20]));
    si = 32'($signed({i[31:25], i[11:7]}));
    bi = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    ji = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    ui = {i[31:12], 12'h000};
    e = '0;
    e.op = i[6:2];
    e.f3 = i[14:12];
    if (i[1:0] != 2'b11) begin
      e.ill = 1'b1;
      return e;
    end
    case (i[6:2])
      5'b01100: begin e.s1 = opnd(i[19:15]); e.s2 = opnd(i[24:20]); e.f7 = i[30]; e.wen = 1; end
      5'b00100: begin
        e.s1  = opnd(i[19:15]);
        e.s2  = (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? {27'd0, i[24:20]} : ii;
        e.f7  = (i[14:12] == 3'b101) ? i[30] : 1'b0;
        e.wen = 1;
      end
      5'b01101: begin e.s2 = ui; e.wen = 1; end
      5'b00101: begin e.s1 = p; e.s2 = ui; e.wen = 1; end
      5'b00000: begin e.s1 = opnd(i[19:15]); e.s2 = ii; e.wen = 1; end
      5'b01000: begin e.s1 = opnd(i[19:15]); e.s2 = si; e.sd = opnd(i[24:20]); end
      5'b11011: begin e.s1 = p; e.imm = ji; e.wen = 1; end
      5'b11001: begin e.s1 = p; e.imm = ii; e.sd = opnd(i[19:15]); e.wen = 1; end
      5'b11000: begin e.s1 = opnd(i[19:15]); e.s2 = opnd(i[24:20]); e.imm = bi; end
      default:  e.ill = 1'b1;
    endcase
    if (e.wen) e.rd = i[11:7];
    return e;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_rf[k] = 32'd0;
    m_pend = '0;
    m_vld  = 1'b0;
    m_out  = '0;
  endtask

  task automatic drive(input logic iv, input logic [31:0] i, input logic [31:0] p,
                       input logic ir, input logic wv, input logic [4:0] wr,
                       input logic [31:0] wd);
    inst_valid = iv; inst = i; pc = p; iss_ready = ir;
    wb_valid = wv; wb_rd = wr; wb_data = wd;
  endtask

  task automatic check_out(input string tag);
    chk({tag, ".valid"}, iss_valid, m_vld);
    if (m_vld) begin
      chk({tag, ".op"},   opcode,       m_out.op);
      chk({tag, ".f3"},   func3,        m_out.f3);
      chk({tag, ".f7"},   func7,        m_out.f7);
      chk({tag, ".src1"}, alu_src1,     m_out.s1);
      chk({tag, ".src2"}, alu_src2,     m_out.s2);
      chk({tag, ".sd"},   iss_rs2_data, m_out.sd);
      chk({tag, ".imm"},  iss_imm,      m_out.imm);
      chk({tag, ".rd"},   iss_rd,       m_out.rd);
      chk({tag, ".wen"},  iss_wen,      m_out.wen);
      chk({tag, ".ill"},  iss_illegal,  m_out.ill);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, ".valid"}, iss_valid, 0);
    chk({tag, ".op"},    opcode, 0);
    chk({tag, ".f3"},    func3, 0);
    chk({tag, ".f7"},    func7, 0);
    chk({tag, ".src1"},  alu_src1, 0);
    chk({tag, ".src2"},  alu_src2, 0);
    chk({tag, ".sd"},    iss_rs2_data, 0);
    chk({tag, ".imm"},   iss_imm, 0);
    chk({tag, ".rd"},    iss_rd, 0);
    chk({tag, ".wen"},   iss_wen, 0);
    chk({tag, ".ill"},   iss_illegal, 0);
  endtask

  // One clock: inputs are already driven (just after a rising edge).
  task automatic cycle(input string tag);
    bit   rdy, acc;
    exp_t d;
    #1;
    rdy = (!m_vld || iss_ready) && !m_hazard(inst);
    chk({tag, ".rdy"}, inst_ready, rdy);
    acc = inst_valid && rdy;
    d   = model_dec(inst, pc);
    @(posedge clk);
    if (wb_valid && wb_rd != 5'd0) m_rf[wb_rd] = wb_data;
    if (wb_valid) m_pend[wb_rd] = 1'b0;
    if (acc) begin
      if (d.wen && d.rd != 5'd0) m_pend[d.rd] = 1'b1;
      m_vld = 1'b1;
      m_out = d;
    end else if (iss_ready) begin
      m_vld = 1'b0;
    end
    #1;
    check_out(tag);
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] i;
    i = $urandom;
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 10))
      0: i[6:0] = 7'b0110011;
      1: i[6:0] = 7'b0010011;
      2: i[6:0] = 7'b0110111;
      3: i[6:0] = 7'b0010111;
      4: i[6:0] = 7'b0000011;
      5: i[6:0] = 7'b0100011;
      6: i[6:0] = 7'b1101111;
      7: i[6:0] = 7'b1100111;
      8: i[6:0] = 7'b1100011;
      9: i[1:0] = 2'($urandom_range(0, 2));
      default: i[6:0] = 7'b1111111;
    endcase
    return i;
  endfunction

  initial begin
    // Reset state
    rst_n = 1'b0;
    drive(0, 32'd0, 32'd0, 1, 0, 5'd0, 32'd0);
    model_reset();
    #2;
    reset_chk("rst");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    cycle("rel");

    // Writeback x1=5, x2=7, then ADD x3,x1,x2
    drive(0, 32'd0, 32'd0, 1, 1, 5'd1, 32'd5);  cycle("wb1");
    drive(0, 32'd0, 32'd0, 1, 1, 5'd2, 32'd7);  cycle("wb2");
    drive(1, 32'h002081B3, 32'h100, 1, 0, 5'd0, 32'd0); cycle("add");
    chk("add.op_k",   opcode, 5'b01100);
    chk("add.f3_k",   func3, 3'b000);
    chk("add.f7_k",   func7, 0);
    chk("add.src1_k", alu_src1, 5);
    chk("add.src2_k", alu_src2, 7);
    chk("add.wen_k",  iss_wen, 1);
    chk("add.rd_k",   iss_rd, 3);

    // ADDI x4,x3,-1 blocked on pending x3 until its writeback, then bypassed
    drive(1, 32'hFFF18213, 32'h104, 1, 0, 5'd0, 32'd0);
    cycle("haz0"); chk("haz0.rdy_k", inst_ready, 0);
    cycle("haz1"); chk("haz1.valid_k", iss_valid, 0);
    drive(1, 32'hFFF18213, 32'h104, 1, 1, 5'd3, 32'd12);
    cycle("byp");
    chk("byp.src1_k", alu_src1, 12);
    chk("byp.src2_k", alu_src2, 32'hFFFFFFFF);

    // SRAI x5,x1,3
    drive(1, 32'h4030D293, 32'h108, 1, 0, 5'd0, 32'd0); cycle("srai");
    chk("srai.f3_k",   func3, 3'b101);
    chk("srai.f7_k",   func7, 1);
    chk("srai.src2_k", alu_src2, 3);

    // LUI x6,0x12345 held for 4 cycles of backpressure, then a single issue
    drive(1, 32'h12345337, 32'h10C, 1, 0, 5'd0, 32'd0); cycle("lui");
    for (int k = 0; k < 4; k++) begin
      drive(1, 32'h00100393, 32'h110, 0, 0, 5'd0, 32'd0);
      cycle("lui_hold");
      chk("lui_hold.src2_k", alu_src2, 32'h12345000);
      chk("lui_hold.valid_k", iss_valid, 1);
      chk("lui_hold.rdy_k", inst_ready, 0);
    end
    drive(0, 32'd0, 32'h110, 1, 0, 5'd0, 32'd0); cycle("lui_go");
    chk("lui_go.valid_k", iss_valid, 0);

    // Illegal word, stalled, then reset mid-stall
    drive(1, 32'hFFFFFFFF, 32'h114, 0, 0, 5'd0, 32'd0); cycle("ill");
    chk("ill.ill_k", iss_illegal, 1);
    chk("ill.wen_k", iss_wen, 0);
    drive(0, 32'd0, 32'h118, 0, 0, 5'd0, 32'd0); cycle("ill_hold");
    rst_n = 1'b0;
    #1;
    model_reset();
    reset_chk("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    // ADD x7,x4,x5: x4/x5 were pending before reset and must no longer block
    drive(1, 32'h005203B3, 32'h200, 1, 0, 5'd0, 32'd0);
    #1;
    chk("post_rst.rdy_k", inst_ready, 1);
    cycle("post_rst");
    chk("post_rst.src1_k", alu_src1, 0);
    chk("post_rst.src2_k", alu_src2, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 9) < 7, rnd_inst(), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 4,
            5'($urandom_range(0, 7)), $urandom);
      cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
